// File: rtl/timer_core.sv
// Purpose: mm:ss BCD countdown timer with start/pause and clear buttons, 1 s tick from a prescaler.
// Latency: a button press acts 2 edges after it is first sampled (1 edge with the synchroniser bypassed).
// Backpressure: none; each button press yields one single-cycle pulse that is consumed on the same edge.
module timer_core #(
   parameter int TICK_DIV = 50000000,
   parameter bit SYNC_EN  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_clear,
   input  logic [3:0] preset_mDecimal,
   input  logic [3:0] preset_mUnit,
   input  logic [3:0] preset_sDecimal,
   input  logic [3:0] preset_sUnit,
   output logic [3:0] mDecimal,
   output logic [3:0] mUnit,
   output logic [3:0] sDecimal,
   output logic [3:0] sUnit,
   output logic [2:0] actualState,
   output logic       alarm
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RUN    = 3'd1,
      PAUSED = 3'd2,
      DONE   = 3'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [1:0]    start_sync;
   logic [1:0]    clear_sync;
   logic          start_lvl;
   logic          clear_lvl;
   logic          start_prev;
   logic          clear_prev;
   logic [2:0]    warm;
   logic          edge_arm;
   logic          start_pls;
   logic          clear_pls;

   logic [PW-1:0] presc;
   logic          tick;

   logic [3:0]    pre_md;
   logic [3:0]    pre_mu;
   logic [3:0]    pre_sd;
   logic [3:0]    pre_su;
   logic          preset_nz;

   logic [3:0]    dec_md;
   logic [3:0]    dec_mu;
   logic [3:0]    dec_sd;
   logic [3:0]    dec_su;
   logic          dec_zero;

   function automatic logic [3:0] clamp_max(input logic [3:0] d, input logic [3:0] lim);
      return (d > lim) ? lim : d;
   endfunction

   // Button synchronisers: two flops in series; the bypass taps after the first flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_sync <= 2'b00;
         clear_sync <= 2'b00;
      end else begin
         start_sync <= {start_sync[0], btn_start};
         clear_sync <= {clear_sync[0], btn_clear};
      end
   end

   assign start_lvl = SYNC_EN ? start_sync[1] : start_sync[0];
   assign clear_lvl = SYNC_EN ? clear_sync[1] : clear_sync[0];

   // Edge-detect history plus a warm-up chain: no pulse until the history holds a real sample,
   // so a button held through reset release is seen as already pressed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_prev <= 1'b0;
         clear_prev <= 1'b0;
         warm       <= 3'b000;
      end else begin
         start_prev <= start_lvl;
         clear_prev <= clear_lvl;
         warm       <= {warm[1:0], 1'b1};
      end
   end

   assign edge_arm  = SYNC_EN ? warm[2] : warm[1];
   assign start_pls = edge_arm & start_lvl & ~start_prev;
   assign clear_pls = edge_arm & clear_lvl & ~clear_prev;

   // Clamp the preset into legal BCD ranges.
   always_comb begin
      pre_md    = clamp_max(preset_mDecimal, 4'd9);
      pre_mu    = clamp_max(preset_mUnit,    4'd9);
      pre_sd    = clamp_max(preset_sDecimal, 4'd5);
      pre_su    = clamp_max(preset_sUnit,    4'd9);
      preset_nz = ({pre_md, pre_mu, pre_sd, pre_su} != 16'h0000);
   end

   assign tick = (state == RUN) && (presc == PW'(TICK_DIV - 1));

   // One-second BCD decrement with borrow ripple; 00:00 stays 00:00.
   always_comb begin
      dec_md = mDecimal;
      dec_mu = mUnit;
      dec_sd = sDecimal;
      dec_su = sUnit;
      if (sUnit != 4'd0) begin
         dec_su = sUnit - 4'd1;
      end else if ({mDecimal, mUnit, sDecimal} != 12'h000) begin
         dec_su = 4'd9;
         if (sDecimal != 4'd0) begin
            dec_sd = sDecimal - 4'd1;
         end else begin
            dec_sd = 4'd5;
            if (mUnit != 4'd0) begin
               dec_mu = mUnit - 4'd1;
            end else begin
               dec_mu = 4'd9;
               dec_md = mDecimal - 4'd1;
            end
         end
      end
      dec_zero = ({dec_md, dec_mu, dec_sd, dec_su} == 16'h0000);
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: clear wins over everything, expiry wins over pause.
   always_comb begin
      state_nxt = state;
      if (clear_pls) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start_pls) begin
                  state_nxt = preset_nz ? RUN : DONE;
               end
            end
            RUN: begin
               if (tick && dec_zero) begin
                  state_nxt = DONE;
               end else if (start_pls) begin
                  state_nxt = PAUSED;
               end
            end
            PAUSED: begin
               if (start_pls) begin
                  state_nxt = RUN;
               end
            end
            DONE: begin
               state_nxt = DONE;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // Prescaler: counts only while running, holds through a pause, zero when idle or expired.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc <= '0;
      end else if (state_nxt == IDLE || state_nxt == DONE) begin
         presc <= '0;
      end else if (state == RUN) begin
         presc <= tick ? '0 : presc + 1'b1;
      end
   end

   // Digit registers: reload the preset when idle or cleared, decrement on tick, else hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mDecimal <= 4'd0;
         mUnit    <= 4'd0;
         sDecimal <= 4'd0;
         sUnit    <= 4'd0;
      end else if (clear_pls) begin
         mDecimal <= pre_md;
         mUnit    <= pre_mu;
         sDecimal <= pre_sd;
         sUnit    <= pre_su;
      end else begin
         case (state)
            RUN: begin
               if (tick) begin
                  mDecimal <= dec_md;
                  mUnit    <= dec_mu;
                  sDecimal <= dec_sd;
                  sUnit    <= dec_su;
               end
            end
            PAUSED, DONE: begin
               mDecimal <= mDecimal;
               mUnit    <= mUnit;
               sDecimal <= sDecimal;
               sUnit    <= sUnit;
            end
            default: begin
               mDecimal <= pre_md;
               mUnit    <= pre_mu;
               sDecimal <= pre_sd;
               sUnit    <= pre_su;
            end
         endcase
      end
   end

   // Alarm tracks the DONE state on the same edge the state register updates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alarm <= 1'b0;
      end else begin
         alarm <= (state_nxt == DONE);
      end
   end

   assign actualState = state;

endmodule
